// File: rtl/dmem_if.sv
// Data-memory bus between a core (master) and a memory responder (slave).
// The core holds its enables until it sees the one-cycle ready pulse.
interface dmem_if;
    logic [31:0] dmem_addr;
    logic        dmem_r_enable;
    logic        dmem_w_enable;
    logic [1:0]  dmem_w_size;
    logic [31:0] dmem_w_data;
    logic [31:0] dmem_r_data;
    logic        dmem_ready;
    logic        dmem_err;

    modport master (
        output dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
        input  dmem_r_data, dmem_ready, dmem_err
    );

    modport slave (
        input  dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
        output dmem_r_data, dmem_ready, dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a fixed response latency, byte/half/word
// writes, and an error pulse for malformed or out-of-range requests.

// Byte-lane write steering: decides whether this lane is written and which
// byte of the right-justified write data lands in it.
module dmem_lane #(
    parameter int LANE  = 0,
    parameter int VEC_W = 8
) (
    input  logic [1:0]         size,
    input  logic [1:0]         offset,
    input  logic [4*VEC_W-1:0] w_data,
    output logic               we,
    output logic [VEC_W-1:0]   data
);
    localparam logic [1:0] LANE_ID = 2'(LANE);

    always_comb begin
        we   = 1'b0;
        data = w_data[VEC_W-1:0];
        case (size)
            2'b00: we = (offset == LANE_ID);
            2'b01: begin
                we   = (offset[1] == LANE_ID[1]);
                data = LANE_ID[0] ? w_data[2*VEC_W-1:VEC_W] : w_data[VEC_W-1:0];
            end
            2'b10: begin
                we   = 1'b1;
                data = w_data[LANE*VEC_W +: VEC_W];
            end
            default: we = 1'b0;
        endcase
    end
endmodule

module dmem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave dmem
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int ADDR_MSB  = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH_WORDS];

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    req_t       req_q, req_live, req_cur;
    logic       err_q;
    logic [31:0] r_data_q;

    logic       accept, enter_resp, cur_err, mem_wr;
    logic [IDX_W-1:0] cur_idx;
    logic [NUM_LANES-1:0]            lane_we;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_byte;

    assign req_live = '{rd:    dmem.dmem_r_enable,
                        wr:    dmem.dmem_w_enable,
                        size:  dmem.dmem_w_size,
                        addr:  dmem.dmem_addr,
                        wdata: dmem.dmem_w_data};

    assign accept = (state == IDLE) && (dmem.dmem_r_enable || dmem.dmem_w_enable);

    // With zero latency the access happens on the accepting edge itself, so the
    // live inputs stand in for the not-yet-latched request.
    assign req_cur = (state == IDLE) ? req_live : req_q;
    assign cur_idx = req_cur.addr[ADDR_MSB:2];

    assign cur_err = (req_cur.rd && req_cur.wr)
                   || (req_cur.wr && req_cur.size == 2'b11)
                   || (req_cur.wr && req_cur.size == 2'b01 && req_cur.addr[0])
                   || (req_cur.wr && req_cur.size == 2'b10 && req_cur.addr[1:0] != 2'b00)
                   || ({2'b00, req_cur.addr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign mem_wr     = enter_resp && !cur_err && req_cur.wr && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_q    <= '0;
            err_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) req_q <= req_live;
            if (enter_resp) begin
                err_q <= cur_err;
                if (!cur_err && req_cur.rd) r_data_q <= mem[cur_idx];
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
            .size   (req_cur.size),
            .offset (req_cur.addr[1:0]),
            .w_data (req_cur.wdata),
            .we     (lane_we[i]),
            .data   (lane_byte[i])
        );
    end

    // Storage has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_we[i]) mem[cur_idx][i] <= lane_byte[i];
            end
        end
    end

    assign dmem.dmem_ready  = (state == RESP);
    assign dmem.dmem_err    = err_q && (state == RESP);
    assign dmem.dmem_r_data = r_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 1, 0, 4) with one shared request stream and
// checks them against a transaction-level model plus literal expectations.
module tb_dmem_responder;
    localparam int LAT [3] = '{1, 0, 4};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic re, we;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_if if_l1 ();
    dmem_if if_l0 ();
    dmem_if if_l4 ();

    assign if_l1.dmem_addr = addr;  assign if_l1.dmem_r_enable = re;  assign if_l1.dmem_w_enable = we;
    assign if_l1.dmem_w_size = size; assign if_l1.dmem_w_data = wdata;
    assign if_l0.dmem_addr = addr;  assign if_l0.dmem_r_enable = re;  assign if_l0.dmem_w_enable = we;
    assign if_l0.dmem_w_size = size; assign if_l0.dmem_w_data = wdata;
    assign if_l4.dmem_addr = addr;  assign if_l4.dmem_r_enable = re;  assign if_l4.dmem_w_enable = we;
    assign if_l4.dmem_w_size = size; assign if_l4.dmem_w_data = wdata;

    dmem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .dmem(if_l1));
    dmem_responder #(.LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .dmem(if_l0));
    dmem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .dmem(if_l4));

    logic [2:0]       obs_ready, obs_err;
    logic [2:0][31:0] obs_rdata;
    assign obs_ready = {if_l4.dmem_ready, if_l0.dmem_ready, if_l1.dmem_ready};
    assign obs_err   = {if_l4.dmem_err,   if_l0.dmem_err,   if_l1.dmem_err};
    assign obs_rdata = {if_l4.dmem_r_data, if_l0.dmem_r_data, if_l1.dmem_r_data};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_busy [3];
    bit          m_resp [3];
    int          m_due  [3];
    logic        m_rd [3], m_wr [3];
    logic [1:0]  m_sz [3];
    logic [31:0] m_a [3], m_d [3];
    logic [31:0] mmem [3][1024];
    logic        exp_ready [3] = '{0, 0, 0};
    logic        exp_err   [3] = '{0, 0, 0};
    logic [31:0] exp_rdata [3] = '{0, 0, 0};

    task automatic model_access(input int k);
        logic [31:0] a;
        bit e;
        a = m_a[k];
        e = (m_rd[k] && m_wr[k]) || (m_wr[k] && m_sz[k] == 2'd3)
            || (m_wr[k] && m_sz[k] == 2'd1 && a[0])
            || (m_wr[k] && m_sz[k] == 2'd2 && a[1:0] != 2'd0)
            || (a[31:2] >= 30'd1024);
        if (!e && m_wr[k]) begin
            case (m_sz[k])
                2'd0: mmem[k][a[11:2]][int'(a[1:0]) * 8 +: 8] = m_d[k][7:0];
                2'd1: mmem[k][a[11:2]][int'(a[1]) * 16 +: 16] = m_d[k][15:0];
                default: mmem[k][a[11:2]] = m_d[k];
            endcase
        end
        if (!e && m_rd[k]) exp_rdata[k] = mmem[k][a[11:2]];
        m_busy[k] = 0;
        m_resp[k] = 1;
        exp_ready[k] = 1;
        exp_err[k] = e;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 0; m_resp[k] = 0;
                exp_ready[k] = 0; exp_err[k] = 0; exp_rdata[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (m_resp[k]) begin
                    m_resp[k] = 0; exp_ready[k] = 0; exp_err[k] = 0;
                end else if (m_busy[k]) begin
                    if (cyc == m_due[k]) model_access(k);
                end else if (re || we) begin
                    m_rd[k] = re; m_wr[k] = we; m_sz[k] = size; m_a[k] = addr; m_d[k] = wdata;
                    m_due[k] = cyc + LAT[k];
                    if (LAT[k] == 0) model_access(k);
                    else m_busy[k] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cyc%0d L%0d ready", cyc, LAT[k]), {31'd0, obs_ready[k]}, {31'd0, exp_ready[k]});
            check($sformatf("cyc%0d L%0d err", cyc, LAT[k]), {31'd0, obs_err[k]}, {31'd0, exp_err[k]});
            check($sformatf("cyc%0d L%0d r_data", cyc, LAT[k]), obs_rdata[k], exp_rdata[k]);
        end
    end

    // ---------------- directed stimulus ----------------
    int          lat_seen [3];
    logic        err_seen [3];
    logic [31:0] rd_seen  [3];

    // One-edge request, then scramble the inputs and watch 8 cycles for each ready.
    task automatic req(input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input bit sync = 1'b1);
        if (sync) @(negedge clk);
        re = r; we = w; size = sz; addr = a; wdata = d;
        @(negedge clk);
        re = 0; we = 0; size = 2'b11; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 3; k++) begin
            lat_seen[k] = 0; err_seen[k] = 0; rd_seen[k] = 0;
        end
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (obs_ready[k] && lat_seen[k] == 0) begin
                    lat_seen[k] = n; err_seen[k] = obs_err[k]; rd_seen[k] = obs_rdata[k];
                end
            end
        end
    endtask

    task automatic expect_resp(input string name, input logic e, input logic [31:0] rd);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s L%0d latency", name, LAT[k]), lat_seen[k], LAT[k] + 1);
            check($sformatf("%s L%0d err", name, LAT[k]), {31'd0, err_seen[k]}, {31'd0, e});
            check($sformatf("%s L%0d r_data", name, LAT[k]), rd_seen[k], rd);
        end
    endtask

    int q [3][$];
    int cnt4;

    initial begin
        reset = 1; re = 0; we = 0; size = 0; addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        check("reset ready", {29'd0, obs_ready}, 32'd0);
        check("reset err", {29'd0, obs_err}, 32'd0);
        check("reset r_data L1", obs_rdata[0], 32'd0);

        // first acceptance on the very first edge after reset release
        reset = 0;
        req(0, 1, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
        check("wr 0x10 L1 latency", lat_seen[0], 2);
        expect_resp("wr 0x10", 0, 32'h0);
        req(1, 0, 2'b00, 32'h10, 32'h0);
        expect_resp("rd 0x10", 0, 32'hDEAD_BEEF);

        req(0, 1, 2'b10, 32'h20, 32'h0000_0000);
        req(0, 1, 2'b00, 32'h22, 32'hFFFF_FFAB);
        req(0, 1, 2'b01, 32'h20, 32'hFFFF_1234);
        expect_resp("half 0x20", 0, 32'hDEAD_BEEF);
        req(1, 0, 2'b00, 32'h21, 32'h0);
        expect_resp("rd 0x21", 0, 32'h00AB_1234);

        req(0, 1, 2'b01, 32'h23, 32'h0000_FFFF);
        expect_resp("half misaligned", 1, 32'h00AB_1234);
        req(0, 1, 2'b10, 32'h22, 32'hFFFF_FFFF);
        expect_resp("word misaligned", 1, 32'h00AB_1234);
        req(0, 1, 2'b11, 32'h20, 32'hFFFF_FFFF);
        expect_resp("size 11", 1, 32'h00AB_1234);
        req(1, 0, 2'b00, 32'h20, 32'h0);
        expect_resp("rd after errs", 0, 32'h00AB_1234);
        req(1, 0, 2'b00, 32'h4000, 32'h0);
        expect_resp("rd 0x4000", 1, 32'h00AB_1234);

        req(0, 1, 2'b00, 32'h23, 32'h0000_005A);
        req(1, 0, 2'b00, 32'h20, 32'h0);
        expect_resp("byte lane3", 0, 32'h5AAB_1234);
        req(0, 1, 2'b01, 32'h22, 32'h0000_9876);
        req(1, 0, 2'b00, 32'h23, 32'h0);
        expect_resp("half upper", 0, 32'h9876_1234);

        req(0, 1, 2'b10, 32'hFFC, 32'hCAFE_F00D);
        req(1, 0, 2'b00, 32'hFFF, 32'h0);
        expect_resp("rd last word", 0, 32'hCAFE_F00D);
        req(1, 0, 2'b00, 32'h1000, 32'h0);
        expect_resp("rd past end", 1, 32'hCAFE_F00D);

        req(1, 1, 2'b10, 32'h20, 32'h1111_1111);
        expect_resp("rd+wr both", 1, 32'hCAFE_F00D);
        req(1, 0, 2'b00, 32'h20, 32'h0);
        expect_resp("rd after both", 0, 32'h9876_1234);

        // enables held continuously: pulses LATENCY+2 cycles apart
        @(negedge clk);
        re = 1; we = 0; addr = 32'h10;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (obs_ready[k]) q[k].push_back(n);
        end
        re = 0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b L%0d gap", LAT[k]),
                  (q[k].size() >= 2) ? q[k][1] - q[k][0] : -1, LAT[k] + 2);
        end
        repeat (8) @(negedge clk);

        // reset while LATENCY=4 write waits: write dropped, storage kept
        req(0, 1, 2'b10, 32'h30, 32'h0000_0000);
        @(negedge clk);
        we = 1; size = 2'b10; addr = 32'h30; wdata = 32'h5555_5555;
        @(negedge clk);
        we = 0;
        #2 reset = 1;
        #1 check("async reset drops ready", {29'd0, obs_ready}, 32'd0);
        #1 reset = 0;
        cnt4 = 0;
        repeat (8) begin
            @(negedge clk);
            if (obs_ready[2]) cnt4++;
        end
        check("no ready after reset L4", cnt4, 0);
        req(1, 0, 2'b00, 32'h30, 32'h0);
        check("post-reset L4 latency", lat_seen[2], 5);
        check("post-reset L4 err", {31'd0, err_seen[2]}, 32'd0);
        check("post-reset L0 word", rd_seen[1], 32'h5555_5555);
        check("post-reset L1 word", rd_seen[0], 32'h0);
        check("post-reset L4 word", rd_seen[2], 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end
endmodule
